flash_read_sequencer: RTL and testbench
=======================================

Name: flash_read_sequencer

Overview:
- Requester side of the FlashTimer start/done handshake.
- Sequences byte-wide parallel NOR flash reads (score table storage): drives address, CE/OE, then raises `timer_start` and holds it until the timer answers `timer_done`.
- Captures `SF_D` on each `timer_done`, streams bytes out with a one-cycle valid strobe, and auto-increments the address for bursts.
- Sits between scoreboard logic (requester) and the flash pins plus a FlashTimer instance.

Parameters:
- ADDR_W, 24, flash byte-address width.
- DATA_W, 8, flash data width.
- TIMEOUT_CYCLES, 1023, watchdog limit per byte. Used only with FLASH_READ_TIMEOUT_EN.

Ports:
- CLK_50MHZ  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous, active-low reset.
- req  in  1  start burst. Sampled only in IDLE.
- start_addr  in  ADDR_W  first byte address, latched with req.
- len  in  8  byte count. 0 means 256.
- busy  out  1  high from the cycle after req acceptance until return to IDLE.
- data_out  out  DATA_W  last captured byte.
- data_valid  out  1  one-cycle strobe per captured byte.
- last  out  1  coincident with data_valid on the final byte of a burst.
- error  out  1  timeout flag, sticky until next accepted req. Tied 0 without the optional feature.
- SF_A  out  ADDR_W  flash address.
- SF_D  in  DATA_W  flash data.
- SF_CE0  out  1  chip enable, active-low.
- SF_OE  out  1  output enable, active-low.
- SF_WE  out  1  write enable, constant 1.
- timer_start  out  1  request to FlashTimer.
- timer_done  in  1  FlashTimer completion.

Behaviour:
- Reset (RST=0, asynchronous):
  - State = IDLE; busy=0; data_valid=0; last=0; error=0.
  - data_out=0; SF_A=0; SF_CE0=1; SF_OE=1; timer_start=0; internal counters=0.
- IDLE: req=1 latches start_addr and len (0 loaded as 256 in a 9-bit counter), clears error, goes to SETUP. busy=1 from the next cycle.
- SETUP:
  - Drives SF_A=addr, SF_CE0=0, SF_OE=0.
  - If timer_done=0: sets timer_start=1 and goes to WAIT.
  - If timer_done=1 (stale handshake): stays in SETUP with timer_start=0 until done drops.
- WAIT:
  - timer_start held 1.
  - On the first edge with timer_done=1:
    - data_out<=SF_D; data_valid<=1; last<=(count==1); timer_start<=0.
    - addr<=addr+1, wrapping from 2^ADDR_W-1 to 0.
    - count<=count-1; go to RELEASE.
  - Latency from SETUP entry to data_valid = 2 cycles plus the timer's done delay.
- RELEASE:
  - timer_start=0; CE/OE stay low.
  - On the edge with timer_done=0: if count==0 go to IDLE (SF_CE0=1, SF_OE=1, busy=0), else go to SETUP.
- req while busy is ignored. It is not queued.
- data_valid and last are single-cycle pulses and are 0 in all other cycles.
- SF_A is stable from SETUP entry through the capture edge.
- Handshake rules:
  - timer_start never rises while timer_done=1.
  - timer_start never falls before timer_done is seen.
- Reset mid-burst aborts immediately: pins return to idle levels and no partial data_valid is produced.

Optional Feature:
- Macro: FLASH_READ_TIMEOUT_EN.
- With the macro defined:
  - A 10-bit watchdog counts cycles in WAIT and clears on entering WAIT.
  - If it reaches TIMEOUT_CYCLES without timer_done: timer_start<=0, error<=1, SF_CE0/SF_OE<=1, go to IDLE (busy=0). No data_valid is produced.
- Without the macro: no watchdog logic; error is constant 0; WAIT waits indefinitely.

Test Plan:
- Single byte: start_addr=0x000010, len=1, flash model returns 0xA5, timer done after 10 cycles -> one data_valid with data_out=0xA5 and last=1; busy falls 1 cycle after done drops; timer_start high exactly from SETUP+1 until the done edge.
- Burst: start_addr=0x000100, len=3, memory bytes 0x11,0x22,0x33 -> three data_valid pulses in order; last only on 0x33; SF_A sequence 0x100, 0x101, 0x102; CE stays low throughout.
- len=0 -> exactly 256 data_valid pulses; SF_A advances 0x000000..0x0000FF.
- Wrap and stale handshake: start_addr=0xFFFFFF, len=2 -> SF_A=0xFFFFFF then 0x000000. Separately, timer_done held 1 at req -> timer_start stays 0 until done drops.
- req pulsed during a busy burst -> ignored; byte count unchanged. RST pulsed low mid-WAIT -> timer_start=0, SF_CE0=1, busy=0 within the same cycle; no further data_valid.
- With FLASH_READ_TIMEOUT_EN and TIMEOUT_CYCLES=20, timer_done never asserted -> error=1 and busy=0 after 20 WAIT cycles; next req clears error.

Source files
------------

// File: rtl/flash_read_sequencer.sv
// Byte-wide parallel NOR flash read sequencer using the FlashTimer start/done handshake.
// Optional per-byte watchdog enabled by defining FLASH_READ_TIMEOUT_EN.
module flash_read_sequencer #(
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              req,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        len,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              last,
  output logic              error,
  output logic [ADDR_W-1:0] SF_A,
  input  logic [DATA_W-1:0] SF_D,
  output logic              SF_CE0,
  output logic              SF_OE,
  output logic              SF_WE,
  output logic              timer_start,
  input  logic              timer_done
);

  typedef enum logic [1:0] {StIdle, StSetup, StWait, StRelease} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_count;

`ifdef FLASH_READ_TIMEOUT_EN
  localparam logic [9:0] WdogLast = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] r_wdog;
  logic       r_error;

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign SF_WE = 1'b1;

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_count     <= '0;
      busy        <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      last        <= 1'b0;
      SF_A        <= '0;
      SF_CE0      <= 1'b1;
      SF_OE       <= 1'b1;
      timer_start <= 1'b0;
`ifdef FLASH_READ_TIMEOUT_EN
      r_wdog      <= '0;
      r_error     <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      last       <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req) begin
            r_addr  <= start_addr;
            SF_A    <= start_addr;
            // len of 0 encodes a full 256-byte burst
            r_count <= {(len == 8'd0), len};
            busy    <= 1'b1;
            SF_CE0  <= 1'b0;
            SF_OE   <= 1'b0;
            r_state <= StSetup;
`ifdef FLASH_READ_TIMEOUT_EN
            r_error <= 1'b0;
`endif
          end
        end
        StSetup: begin
          // Hold off while a stale done from a previous handshake is still high
          if (!timer_done) begin
            timer_start <= 1'b1;
            r_state     <= StWait;
`ifdef FLASH_READ_TIMEOUT_EN
            r_wdog      <= '0;
`endif
          end
        end
        StWait: begin
          if (timer_done) begin
            data_out    <= SF_D;
            data_valid  <= 1'b1;
            last        <= (r_count == 9'd1);
            timer_start <= 1'b0;
            r_addr      <= r_addr + 1'b1;
            r_count     <= r_count - 9'd1;
            r_state     <= StRelease;
          end
`ifdef FLASH_READ_TIMEOUT_EN
          else if (r_wdog == WdogLast) begin
            timer_start <= 1'b0;
            r_error     <= 1'b1;
            SF_CE0      <= 1'b1;
            SF_OE       <= 1'b1;
            busy        <= 1'b0;
            r_state     <= StIdle;
          end else begin
            r_wdog <= r_wdog + 10'd1;
          end
`endif
        end
        StRelease: begin
          if (!timer_done) begin
            if (r_count == 9'd0) begin
              SF_CE0  <= 1'b1;
              SF_OE   <= 1'b1;
              busy    <= 1'b0;
              r_state <= StIdle;
            end else begin
              SF_A    <= r_addr;
              r_state <= StSetup;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Testbench for flash_read_sequencer: flash memory model, randomized FlashTimer model,
// expected-byte queue and handshake monitor.
module tb_flash_read_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [23:0] start_addr;
  logic [7:0]  len;
  logic        busy;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        last;
  logic        error;
  logic [23:0] SF_A;
  logic [7:0]  SF_D;
  logic        SF_CE0;
  logic        SF_OE;
  logic        SF_WE;
  logic        timer_start;
  logic        timer_done;

  logic        t_done;
  logic        force_done;
  logic        timer_en;
  int          fix_delay;
  int          tphase;
  int          tcnt;
  int          drop_cyc;
  int          cyc;
  int          checks;
  int          errors;
  int          n_valid;
  int          v0;
  int          t0;
  int          k;
  logic        prev_ts;
  logic        prev_done;

  logic [23:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  logic        exp_last_q[$];

  flash_read_sequencer #(
    .ADDR_W        (24),
    .DATA_W        (8),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .CLK_50MHZ  (clk),
    .RST        (rst_n),
    .req        (req),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .last       (last),
    .error      (error),
    .SF_A       (SF_A),
    .SF_D       (SF_D),
    .SF_CE0     (SF_CE0),
    .SF_OE      (SF_OE),
    .SF_WE      (SF_WE),
    .timer_start(timer_start),
    .timer_done (timer_done)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000010: mem_byte = 8'hA5;
      24'h000100: mem_byte = 8'h11;
      24'h000101: mem_byte = 8'h22;
      24'h000102: mem_byte = 8'h33;
      default:    mem_byte = a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h3C;
    endcase
  endfunction

  assign SF_D       = mem_byte(SF_A);
  assign timer_done = t_done | force_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "global timeout");
  end

  // FlashTimer model: answers start after a delay, releases done some cycles after start drops.
  initial begin
    t_done   = 1'b0;
    tphase   = 0;
    tcnt     = 0;
    drop_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tphase = 0;
        t_done = 1'b0;
      end else begin
        case (tphase)
          0: if (timer_start && timer_en) begin
               tcnt   = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 5));
               tphase = 1;
             end
          1: if (tcnt == 0) begin
               t_done = 1'b1;
               tphase = 2;
             end else tcnt--;
          2: if (!timer_start) begin
               tcnt   = (fix_delay >= 0) ? 0 : int'($urandom_range(0, 3));
               tphase = 3;
             end
          3: if (tcnt == 0) begin
               t_done   = 1'b0;
               drop_cyc = cyc;
               tphase   = 0;
             end else tcnt--;
          default: tphase = 0;
        endcase
      end
    end
  end

  // Output stream and handshake monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        n_valid++;
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_valid: observed data 0x%0h at SF_A 0x%0h, expected no strobe",
                 data_out, SF_A);
        end else begin
          chk("data_out", data_out, exp_data_q.pop_front());
          chk("last", last, exp_last_q.pop_front());
          chk("sf_a_at_capture", SF_A, exp_addr_q.pop_front());
          chk("ce_low_in_burst", SF_CE0, 1'b0);
        end
      end else begin
        chk("last_without_valid", last, 1'b0);
      end
      if (timer_start && !prev_ts) chk("ts_rise_while_done", prev_done, 1'b0);
      if (!timer_start && prev_ts && !error) chk("ts_fall_before_done", prev_done, 1'b1);
      prev_ts   = timer_start;
      prev_done = timer_done;
    end else begin
      prev_ts   = 1'b0;
      prev_done = timer_done;
    end
  end

  task automatic start_burst(input logic [23:0] a, input logic [7:0] l, input bit chk_ts);
    int n;
    n = (l == 8'd0) ? 256 : int'(l);
    for (int i = 0; i < n; i++) begin
      logic [23:0] ea;
      ea = a + 24'(i);
      exp_addr_q.push_back(ea);
      exp_data_q.push_back(mem_byte(ea));
      exp_last_q.push_back(i == n - 1);
    end
    @(posedge clk);
    #1;
    req        = 1'b1;
    start_addr = a;
    len        = l;
    @(posedge clk);
    #1;
    req        = 1'b0;
    start_addr = 24'($urandom);
    len        = 8'($urandom);
    @(negedge clk);
    chk("busy_on_accept", busy, 1'b1);
    chk("error_cleared", error, 1'b0);
    if (chk_ts) begin
      @(negedge clk);
      chk("ts_after_setup", timer_start, 1'b1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (busy === 1'b1 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $error("FAIL %s_idle_timeout: busy observed %b after %0d cycles, expected 0", tag, busy, w);
    end else begin
      chk({tag, "_busy_fall_lat"}, cyc - drop_cyc, 1);
      chk({tag, "_all_bytes"}, exp_data_q.size(), 0);
      chk({tag, "_ce_idle"}, SF_CE0, 1'b1);
      chk({tag, "_oe_idle"}, SF_OE, 1'b1);
      chk({tag, "_ts_idle"}, timer_start, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    n_valid    = 0;
    prev_ts    = 1'b0;
    prev_done  = 1'b0;
    rst_n      = 1'b0;
    req        = 1'b0;
    start_addr = '0;
    len        = '0;
    force_done = 1'b0;
    timer_en   = 1'b1;
    fix_delay  = -1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_sf_a", SF_A, 24'h0);
    chk("rst_ce", SF_CE0, 1'b1);
    chk("rst_oe", SF_OE, 1'b1);
    chk("rst_we", SF_WE, 1'b1);
    chk("rst_ts", timer_start, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single byte, fixed timer delay.
    fix_delay = 10;
    v0 = n_valid;
    start_burst(24'h000010, 8'd1, 1'b1);
    wait_idle("single");
    chk("single_count", n_valid - v0, 1);
    fix_delay = -1;

    // Three-byte burst with known contents.
    v0 = n_valid;
    start_burst(24'h000100, 8'd3, 1'b1);
    wait_idle("burst3");
    chk("burst3_count", n_valid - v0, 3);

    // len = 0 is a 256-byte burst.
    v0 = n_valid;
    start_burst(24'h000000, 8'd0, 1'b1);
    wait_idle("len0");
    chk("len0_count", n_valid - v0, 256);

    // Address wrap.
    v0 = n_valid;
    start_burst(24'hFFFFFF, 8'd2, 1'b1);
    wait_idle("wrap");
    chk("wrap_count", n_valid - v0, 2);

    // Stale done at request time.
    force_done = 1'b1;
    v0 = n_valid;
    start_burst(24'h000040, 8'd2, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("stale_ts_low", timer_start, 1'b0);
      chk("stale_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1;
    force_done = 1'b0;
    wait_idle("stale");
    chk("stale_count", n_valid - v0, 2);

    // req while busy is ignored.
    v0 = n_valid;
    start_burst(24'h000200, 8'd3, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    req        = 1'b1;
    start_addr = 24'h000300;
    len        = 8'd5;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle("ignore");
    chk("ignore_count", n_valid - v0, 3);

    // Randomized bursts.
    for (int r = 0; r < 6; r++) begin
      logic [23:0] ra;
      logic [7:0]  rl;
      ra = (r == 5) ? 24'hFFFFFD : 24'($urandom);
      rl = 8'($urandom_range(1, 6));
      v0 = n_valid;
      start_burst(ra, rl, 1'b1);
      wait_idle("rand");
      chk("rand_count", n_valid - v0, int'(rl));
    end

    // Reset in the middle of WAIT.
    v0 = n_valid;
    start_burst(24'h000400, 8'd5, 1'b0);
    k = 0;
    @(negedge clk);
    while (timer_start !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_in_wait", timer_start, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ts", timer_start, 1'b0);
    chk("midrst_ce", SF_CE0, 1'b1);
    chk("midrst_oe", SF_OE, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", data_valid, 1'b0);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_valid", n_valid - v0, 0);
    chk("midrst_idle", busy, 1'b0);

`ifdef FLASH_READ_TIMEOUT_EN
    // Watchdog: timer never answers.
    timer_en = 1'b0;
    v0 = n_valid;
    @(posedge clk);
    #1;
    req        = 1'b1;
    start_addr = 24'h000500;
    len        = 8'd1;
    @(posedge clk);
    #1;
    req = 1'b0;
    k = 0;
    @(negedge clk);
    while (timer_start !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    t0 = cyc;
    k  = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wdog_len", cyc - t0, 20);
    chk("wdog_error", error, 1'b1);
    chk("wdog_busy", busy, 1'b0);
    chk("wdog_ts", timer_start, 1'b0);
    chk("wdog_ce", SF_CE0, 1'b1);
    chk("wdog_oe", SF_OE, 1'b1);
    chk("wdog_no_valid", n_valid - v0, 0);
    repeat (3) @(negedge clk);
    chk("wdog_sticky", error, 1'b1);
    timer_en = 1'b1;
    start_burst(24'h000600, 8'd1, 1'b1);
    wait_idle("after_wdog");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
